// File: rtl/ternary_pkg.sv
// Shared trit encodings, op codes and controller states for the ternary serial ALU.
package ternary_pkg;

  // Trit codes as {bit1,bit0}
  localparam logic [1:0] T0   = 2'b00;
  localparam logic [1:0] T1   = 2'b01;
  localparam logic [1:0] T2   = 2'b10;
  localparam logic [1:0] TINV = 2'b11;

  // Operation select codes
  localparam logic [1:0] OP_MIN  = 2'b00;
  localparam logic [1:0] OP_MAX  = 2'b01;
  localparam logic [1:0] OP_CONS = 2'b10;
  localparam logic [1:0] OP_ANY  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit1-dominant interpretation: code 11 reads as 2
  function automatic logic [1:0] tern_norm(input logic [1:0] t);
    return t[1] ? T2 : t;
  endfunction

endpackage

// File: rtl/ternary_trit_op.sv
// Single-trit combinational operator (min / max / consensus / any).
// TERNARY_INVALID_CHECK_EN: flag code 11 and force the result trit to 00;
// otherwise code 11 is read as 2 and the invalid flag stays low.
module ternary_trit_op
  import ternary_pkg::*;
(
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  input  logic [1:0] i_op,
  output logic [1:0] o_res,
  output logic       o_inv
);

  logic [1:0] w_a;
  logic [1:0] w_b;
  logic [1:0] w_r;

  // Operand conditioning, op evaluation and invalid masking
  always_comb begin
`ifdef TERNARY_INVALID_CHECK_EN
    w_a   = i_a;
    w_b   = i_b;
    o_inv = (i_a == TINV) || (i_b == TINV);
`else
    w_a   = tern_norm(i_a);
    w_b   = tern_norm(i_b);
    o_inv = 1'b0;
`endif
    w_r = T1;
    case (i_op)
      OP_MIN:  w_r = (w_a < w_b) ? w_a : w_b;
      OP_MAX:  w_r = (w_a > w_b) ? w_a : w_b;
      OP_CONS: w_r = ((w_a == w_b) && (w_a != T1)) ? w_a : T1;
      OP_ANY: begin
        if (w_a == T1)       w_r = w_b;
        else if (w_b == T1)  w_r = w_a;
        else if (w_a == w_b) w_r = w_a;
        else                 w_r = T1;
      end
      default: w_r = T1;
    endcase
    o_res = o_inv ? T0 : w_r;
  end

endmodule

// File: rtl/ternary_serial_alu.sv
// Trit-serial ternary ALU: accepts an operand pair in IDLE, evaluates one
// trit per cycle LSB first in RUN, presents the word in DONE until consumed.
// TERNARY_INVALID_CHECK_EN enables invalid-code detection (sticky out_err).
module ternary_serial_alu
  import ternary_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               out_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_a;
  logic [2*WIDTH-1:0] r_b;
  logic [1:0]         r_op;
  logic [2*WIDTH-1:0] r_out;
  logic               r_err;
  logic [1:0]         w_a_trit;
  logic [1:0]         w_b_trit;
  logic [1:0]         w_res_trit;
  logic               w_inv;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        if (r_cnt == LAST) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Select the operand trits addressed by the counter
  always_comb begin
    w_a_trit = '0;
    w_b_trit = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_trit = r_a[2*i +: 2];
        w_b_trit = r_b[2*i +: 2];
      end
    end
  end

  ternary_trit_op u_trit_op (
    .i_a   (w_a_trit),
    .i_b   (w_b_trit),
    .i_op  (r_op),
    .o_res (w_res_trit),
    .o_inv (w_inv)
  );

  // Operand latch, trit counter, result accumulation and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_out <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op;
            r_out <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r_cnt == CW'(i)) r_out[2*i +: 2] <= w_res_trit;
          end
          r_err <= r_err | w_inv;
          // Saturate on the last trit so the counter never wraps
          if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out     = r_out;
  assign out_err = r_err;

endmodule

// File: tb/tb_ternary_serial_alu.sv
// Self-checking bench for ternary_serial_alu (WIDTH=4): directed vectors plus
// randomized words against a trit-level arithmetic reference model.
module tb_ternary_serial_alu;

  localparam int W  = 4;
  localparam int DW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out;
  logic          out_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ternary_serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Trit value as the design should interpret it (-1 = invalid)
  function automatic int trit_val(input int code);
`ifdef TERNARY_INVALID_CHECK_EN
    return (code == 3) ? -1 : code;
`else
    return (code == 3) ? 2 : code;
`endif
  endfunction

  function automatic int trit_fn(input int x, input int y, input int f);
    case (f)
      0: return (x < y) ? x : y;
      1: return (x > y) ? x : y;
      2: return (x == y && x != 1) ? x : 1;
      default: begin
        if (x == 1) return y;
        if (y == 1) return x;
        if (x == y) return x;
        return 1;
      end
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] ra, input logic [DW-1:0] rb,
                                             input logic [1:0] rop, output logic rerr);
    logic [DW-1:0] r;
    int x, y, t;
    r    = '0;
    rerr = 1'b0;
    for (int k = 0; k < W; k++) begin
      x = trit_val(int'((ra >> (2*k)) & DW'(3)));
      y = trit_val(int'((rb >> (2*k)) & DW'(3)));
      if (x < 0 || y < 0) begin
        t    = 0;
        rerr = 1'b1;
      end else begin
        t = trit_fn(x, y, int'(rop));
      end
      r = r | (DW'(t) << (2*k));
    end
    return r;
  endfunction

  // One full word: offer, accept, measure latency, optional hold in DONE, drain
  task automatic do_word(input logic [DW-1:0] ta, input logic [DW-1:0] tb_v,
                         input logic [1:0] top, input int hold, input string tag);
    logic [DW-1:0] exp;
    logic          eerr;
    int            n;
    exp = ref_word(ta, tb_v, top, eerr);
    a = ta; b = tb_v; op = top; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    // Inputs must be ignored once the word is latched
    in_valid = 1'($urandom_range(0, 1));
    a  = DW'($urandom);
    b  = DW'($urandom);
    op = 2'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check_eq({tag, "_lat"}, 32'(n), 32'(W));
    check_eq({tag, "_out"}, 32'(out), 32'(exp));
    check_eq({tag, "_err"}, 32'(out_err), 32'(eerr));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a = DW'($urandom);
      check_eq({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
      tick();
      check_eq({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_hold_out"}, 32'(out), 32'(exp));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq({tag, "_done_rdy"}, 32'(in_ready), 32'd0);
    tick();
    check_eq({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] ra, rb, exp;
    logic [1:0]    rop;
    logic          eerr;
    int            n, prev_acc, seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    tick(); tick();
    check_eq("rst_rdy", 32'(in_ready), 32'd1);
    check_eq("rst_vld", 32'(out_valid), 32'd0);
    check_eq("rst_out", 32'(out), 32'd0);
    check_eq("rst_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors
    do_word(8'h64, 8'h4A, 2'b00, 5, "min");
    check_eq("min_const", 32'(ref_word(8'h64, 8'h4A, 2'b00, eerr)), 32'h44);
    do_word(8'h64, 8'h4A, 2'b01, 0, "max");
    do_word(8'h64, 8'h4A, 2'b10, 0, "cons");
    do_word(8'h64, 8'h4A, 2'b11, 1, "any");
    do_word(8'h67, 8'h4A, 2'b00, 0, "inv");

    // Reset in RUN cycle 2 aborts the word
    a = 8'h64; b = 8'h4A; op = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rrun_rdy", 32'(in_ready), 32'd1);
    check_eq("rrun_vld", 32'(out_valid), 32'd0);
    check_eq("rrun_out", 32'(out), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (out_valid) seen++; end
    check_eq("rrun_noemit", 32'(seen), 32'd0);

    // Reset while in DONE
    a = 8'h64; b = 8'h4A; op = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check_eq("rdone_vld", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rdone_idle_vld", 32'(out_valid), 32'd0);
    check_eq("rdone_idle_out", 32'(out), 32'd0);
    check_eq("rdone_idle_rdy", 32'(in_ready), 32'd1);

    // Back-to-back words, out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev_acc  = -1;
    for (int j = 0; j < 8; j++) begin
      ra  = DW'($urandom);
      rb  = DW'($urandom);
      rop = 2'($urandom);
      exp = ref_word(ra, rb, rop, eerr);
      a = ra; b = rb; op = rop;
      n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
      check_eq("b2b_ready", 32'(in_ready), 32'd1);
      if (prev_acc >= 0) check_eq("b2b_spacing", 32'(cyc - prev_acc), 32'(W + 2));
      prev_acc = cyc;
      tick();
      a = DW'($urandom);
      b = DW'($urandom);
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      check_eq("b2b_out", 32'(out), 32'(exp));
      check_eq("b2b_err", 32'(out_err), 32'(eerr));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;

    // Randomized words with random hold times
    for (int j = 0; j < 30; j++) begin
      ra  = DW'($urandom);
      rb  = DW'($urandom);
      rop = 2'($urandom);
      do_word(ra, rb, rop, $urandom_range(0, 3), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
